// File: rtl/sim_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// sim_uart_rx_fifo
//   Simulation UART receiver with a receive FIFO. It sits on a serial line
//   (idle high), recovers frames made of a start bit, DATA_BITS data bits
//   (LSB first), an optional parity bit and STOP_BITS stop bits, and pushes
//   each word into a 2**FIFO_LOG2 deep FIFO that the bench drains with i_rd.
//
//   Optional feature macro: SIM_UART_RX_PARITY_EN
//     defined   : one parity bit follows the data bits; adds ports
//                 i_parity_odd / o_parity_err.
//     undefined : no parity bit in the frame, DATA goes straight to STOP.
//
// Ports
//   i_clk, i_nrst   clock, asynchronous active-low reset
//   i_clken         sample enable; the receiver FSM only advances when high
//   i_rx            serial line (synchronised internally, 2 i_clk latency)
//   i_scaler        half bit period in i_clken ticks (0 behaves as 1)
//   i_rd            pop the FIFO head (ignored while empty)
//   o_rdata         FIFO head word, valid while o_rvalid
//   o_rvalid        FIFO not empty
//   o_count         number of words held
//   i_err_clr       clears the sticky error flags
//   o_frame_err     sticky: a stop bit was sampled low
//   o_overrun       sticky: a word was dropped because the FIFO was full
//   i_parity_odd    (macro) 1 = odd parity, 0 = even parity
//   o_parity_err    (macro) sticky: received parity bit did not match
//   o_dbg_state     current receiver state (state_t encoding)
//
// Handshake: the FIFO head is offered on o_rdata whenever o_rvalid is high;
// a pop happens on any i_clk edge where i_rd && o_rvalid, and the next head
// (or o_rvalid low) appears after that edge. i_rd while empty has no effect.
// -----------------------------------------------------------------------------
module sim_uart_rx_fifo #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int FIFO_LOG2 = 4
) (
  input  logic                 i_clk,
  input  logic                 i_nrst,
  input  logic                 i_clken,
  input  logic                 i_rx,
  input  logic [31:0]          i_scaler,
  input  logic                 i_rd,
  output logic [DATA_BITS-1:0] o_rdata,
  output logic                 o_rvalid,
  output logic [FIFO_LOG2:0]   o_count,
  input  logic                 i_err_clr,
  output logic                 o_frame_err,
  output logic                 o_overrun,
`ifdef SIM_UART_RX_PARITY_EN
  input  logic                 i_parity_odd,
  output logic                 o_parity_err,
`endif
  output logic [2:0]           o_dbg_state
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Line synchroniser (resets to the idle level so reset never looks like a start)
  // ---------------------------------------------------------------------------
  logic rx_meta, rx_s;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------------
  state_t               state, state_n;
  logic [31:0]          cnt, cnt_n;
  logic [31:0]          scaler_q, scaler_n;
  logic [BIT_W-1:0]     bit_idx, bit_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 stop_idx, stop_n;
  logic                 frame_bad, frame_bad_n;
  logic                 push, push_ferr;
  logic [31:0]          scaler_eff, cnt_max;
  logic                 at_mid, at_max;
`ifdef SIM_UART_RX_PARITY_EN
  logic                 par_bad, par_bad_n;
  logic                 push_perr;
`endif

  assign scaler_eff = (i_scaler == 32'd0) ? 32'd1 : i_scaler;
  // scaler_q is captured at start detection, so a scaler change lands at the next frame.
  assign cnt_max    = {scaler_q[30:0], 1'b0} - 32'd1;
  assign at_mid     = (cnt == scaler_q);
  assign at_max     = (cnt == cnt_max);
  assign o_dbg_state = state;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      scaler_q  <= 32'd1;
      bit_idx   <= '0;
      shreg     <= '0;
      stop_idx  <= 1'b0;
      frame_bad <= 1'b0;
`ifdef SIM_UART_RX_PARITY_EN
      par_bad   <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      scaler_q  <= scaler_n;
      bit_idx   <= bit_n;
      shreg     <= shreg_n;
      stop_idx  <= stop_n;
      frame_bad <= frame_bad_n;
`ifdef SIM_UART_RX_PARITY_EN
      par_bad   <= par_bad_n;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    scaler_n    = scaler_q;
    bit_n       = bit_idx;
    shreg_n     = shreg;
    stop_n      = stop_idx;
    frame_bad_n = frame_bad;
    push        = 1'b0;
    push_ferr   = 1'b0;
`ifdef SIM_UART_RX_PARITY_EN
    par_bad_n   = par_bad;
    push_perr   = 1'b0;
`endif
    if (i_clken) begin
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            // The detecting tick counts as cnt 0 of the start bit.
            state_n     = ST_START;
            cnt_n       = 32'd1;
            scaler_n    = scaler_eff;
            bit_n       = '0;
            stop_n      = 1'b0;
            frame_bad_n = 1'b0;
`ifdef SIM_UART_RX_PARITY_EN
            par_bad_n   = 1'b0;
`endif
          end
        end
        ST_START: begin
          cnt_n = cnt + 32'd1;
          if (at_mid && rx_s) begin
            state_n = ST_IDLE;          // glitch shorter than half a bit
            cnt_n   = '0;
          end else if (at_max) begin
            state_n = ST_DATA;
            cnt_n   = '0;
            bit_n   = '0;
          end
        end
        ST_DATA: begin
          cnt_n = cnt + 32'd1;
          if (at_mid) begin
            // LSB first: after DATA_BITS shifts the first bit sits at bit 0.
            shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
            bit_n   = bit_idx + 1'b1;
          end
          if (at_max) begin
            cnt_n = '0;
            // bit_n (not bit_idx) so a scaler of 1, where mid == max, still works.
            if (bit_n == BIT_W'(DATA_BITS)) begin
`ifdef SIM_UART_RX_PARITY_EN
              state_n = ST_PARITY;
`else
              state_n = ST_STOP;
`endif
              stop_n  = 1'b0;
            end
          end
        end
`ifdef SIM_UART_RX_PARITY_EN
        ST_PARITY: begin
          cnt_n = cnt + 32'd1;
          if (at_mid) par_bad_n = (rx_s != ((^shreg) ^ i_parity_odd));
          if (at_max) begin
            state_n = ST_STOP;
            cnt_n   = '0;
            stop_n  = 1'b0;
          end
        end
`endif
        ST_STOP: begin
          cnt_n = cnt + 32'd1;
          if (at_mid) begin
            frame_bad_n = frame_bad | ~rx_s;
            if (stop_idx == 1'(STOP_BITS - 1)) begin
              // Push at the middle of the last stop bit to resync early.
              push      = 1'b1;
              push_ferr = frame_bad | ~rx_s;
`ifdef SIM_UART_RX_PARITY_EN
              push_perr = par_bad;
`endif
              state_n   = ST_IDLE;
              cnt_n     = '0;
            end
          end
          if (state_n == ST_STOP && at_max) begin
            cnt_n  = '0;
            stop_n = 1'b1;
          end
        end
        default: begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [FIFO_LOG2-1:0] wr_ptr, rd_ptr;
  logic                 pop, full, wr_en, overrun_set;

  assign o_rvalid    = (o_count != '0);
  assign full        = (o_count == (FIFO_LOG2+1)'(DEPTH));
  assign pop         = i_rd && o_rvalid;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en       = push && (!full || pop);
  assign overrun_set = push && full && !pop;
  assign o_rdata     = mem[rd_ptr];

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= shreg_n;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   o_count <= o_count + 1'b1;
        2'b01:   o_count <= o_count - 1'b1;
        default: o_count <= o_count;
      endcase
    end
  end

  // Sticky flags: a new error in the same cycle as i_err_clr wins.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
`ifdef SIM_UART_RX_PARITY_EN
      o_parity_err <= 1'b0;
`endif
    end else begin
      if (push_ferr)      o_frame_err <= 1'b1;
      else if (i_err_clr) o_frame_err <= 1'b0;
      if (overrun_set)    o_overrun   <= 1'b1;
      else if (i_err_clr) o_overrun   <= 1'b0;
`ifdef SIM_UART_RX_PARITY_EN
      if (push_perr)      o_parity_err <= 1'b1;
      else if (i_err_clr) o_parity_err <= 1'b0;
`endif
    end
  end

endmodule
